// File: rtl/roy_sensor_pkg.sv
// roy_sensor_pkg: shared defaults, display modes and saturation helper for the sensor tile
package roy_sensor_pkg;
  localparam int DEBOUNCE_CYCLES = 4;
  localparam int GATE_CYCLES = 1024;
  localparam logic [7:0] CNT_MAX = 8'd255;
  localparam logic [4:0] LIVE_MAX = 5'd31;
  typedef enum logic {MODE_RATE = 1'b0, MODE_STATUS = 1'b1} mode_e;
  function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic inc);
    return (inc && v != CNT_MAX) ? v + 8'd1 : v;
  endfunction
endpackage

// File: rtl/roy_sensor_debounce.sv
// roy_sensor_debounce: 2-FF synchroniser, stable-run debouncer and rising-edge pulse
module roy_sensor_debounce #(
  parameter int DEBOUNCE_CYCLES = roy_sensor_pkg::DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic deb,
  output logic evt
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic s1, s, s_prev, deb_d, hold, take;
  logic [CW-1:0] scnt;
  // hold: synchronised level is stable and disagrees with the accepted level
  assign hold = (s == s_prev) && (s != deb);
  assign take = hold && (scnt == CW'(DEBOUNCE_CYCLES - 1));
  assign evt = deb & ~deb_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {s1, s, s_prev, deb, deb_d, scnt} <= '0;
    else begin
      s1 <= raw;
      s <= s1;
      s_prev <= s;
      deb_d <= deb;
      deb <= take ? s : deb;
      scnt <= (hold && !take) ? scnt + 1'b1 : '0;
    end
endmodule

// File: rtl/roy1707018_sensor.sv
// roy1707018_sensor: gated pulse-rate counter with alarm/status display
module roy1707018_sensor #(
  parameter int DEBOUNCE_CYCLES = roy_sensor_pkg::DEBOUNCE_CYCLES,
  parameter int GATE_CYCLES = roy_sensor_pkg::GATE_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out
);
  import roy_sensor_pkg::*;
  localparam int WW = $clog2(GATE_CYCLES);
  logic deb, evt, win_end, alarm_next, ovf, alarm;
  logic [WW-1:0] wcnt;
  logic [7:0] cnt, rate, rate_next;
  logic [5:0] thr;
  logic [4:0] live;
  mode_e mode;
  roy_sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
    .clk(clk),
    .rst_n(rst_n),
    .raw(ui_in[0]),
    .deb(deb),
    .evt(evt)
  );
  assign mode = mode_e'(ui_in[1]);
  assign thr = ui_in[7:2];
  assign win_end = wcnt == WW'(GATE_CYCLES - 1);
  // an event on the closing cycle is folded into the closing window
  assign rate_next = sat_inc(cnt, evt);
  assign alarm_next = (thr != '0) && (rate_next >= {2'b00, thr});
  assign live = (cnt > 8'(LIVE_MAX)) ? LIVE_MAX : cnt[4:0];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wcnt <= '0;
      cnt <= '0;
      rate <= '0;
      ovf <= 1'b0;
      alarm <= 1'b0;
      uo_out <= '0;
    end else begin
      wcnt <= win_end ? '0 : wcnt + 1'b1;
      cnt <= win_end ? '0 : rate_next;
      if (win_end) begin
        rate <= rate_next;
        ovf <= rate_next == CNT_MAX;
        alarm <= alarm_next;
      end
      uo_out <= (mode == MODE_STATUS) ? {alarm, deb, ovf, live} : rate;
    end
endmodule

// File: tb/tb_roy1707018_sensor.sv
// tb_roy1707018_sensor: randomized and directed checks against a run-length/window reference model
module tb_roy1707018_sensor;
  localparam int DEB = 4;
  localparam int GATE = 3072;
  localparam int RUN = DEB + 1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uo_out;
  int checks = 0;
  int errors = 0;
  int n, cur, run, acc, cnt_m, rate_m;
  logic ovf_m, alarm_m, deb_m;
  logic [7:0] exp_out;
  int deb_q[$];
  int evt_q[$];

  roy1707018_sensor #(.DEBOUNCE_CYCLES(DEB), .GATE_CYCLES(GATE)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ui_in(ui_in),
    .uo_out(uo_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s t=%0t got %02h want %02h", tag, $time, got, want);
    end
  endtask

  task automatic model_reset();
    n = 0; cur = 0; run = 0; acc = 0; cnt_m = 0; rate_m = 0;
    ovf_m = 1'b0; alarm_m = 1'b0; deb_m = 1'b0; exp_out = 8'h00;
    deb_q.delete();
    evt_q.delete();
  endtask

  // Raw runs of RUN equal samples are accepted; deb follows 2 edges later, the count 3 edges later.
  task automatic model_step();
    int e, total;
    logic [4:0] live;
    n++;
    live = (cnt_m > 31) ? 5'd31 : 5'(cnt_m);
    exp_out = ui_in[1] ? {alarm_m, deb_m, ovf_m, live} : 8'(rate_m);
    e = (evt_q.size() > 0 && evt_q[0] == n) ? 1 : 0;
    if (e == 1) void'(evt_q.pop_front());
    total = (cnt_m + e > 255) ? 255 : cnt_m + e;
    if (n % GATE == 0) begin
      rate_m = total;
      ovf_m = (total == 255);
      alarm_m = (ui_in[7:2] != 0) && (total >= int'(ui_in[7:2]));
      cnt_m = 0;
    end else cnt_m = total;
    if (deb_q.size() > 0 && deb_q[0] / 2 == n) begin
      deb_m = (deb_q[0] % 2) == 1;
      void'(deb_q.pop_front());
    end
    if (int'(ui_in[0]) == cur) run++;
    else begin
      cur = int'(ui_in[0]);
      run = 1;
    end
    if (run == RUN && cur != acc) begin
      acc = cur;
      deb_q.push_back((n + 2) * 2 + cur);
      if (cur == 1) evt_q.push_back(n + 3);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("cycle", uo_out, exp_out);
  endtask

  task automatic pulse(input int h, input int l);
    ui_in[0] = 1'b1;
    repeat (h) tick();
    ui_in[0] = 1'b0;
    repeat (l) tick();
  endtask

  task automatic to_window_end();
    while (n % GATE != 0) tick();
  endtask

  initial begin
    model_reset();
    repeat (8) begin
      @(negedge clk);
      ui_in = 8'($urandom);
      chk("rst_hold", uo_out, 8'h00);
    end
    ui_in = 8'h00;
    rst_n = 1'b1;
    repeat (2 * GATE) tick();
    chk("idle", uo_out, 8'h00);
    repeat (10) pulse(20, 20);
    to_window_end();
    tick();
    chk("rate10", uo_out, 8'd10);
    to_window_end();
    tick();
    chk("rate0", uo_out, 8'd0);
    repeat (5) pulse(2, 10);
    pulse(3, 10);
    pulse(6, 10);
    to_window_end();
    tick();
    chk("deb_glitch", uo_out, 8'd1);
    repeat (300) pulse(5, 5);
    to_window_end();
    tick();
    chk("sat_rate", uo_out, 8'd255);
    ui_in[1] = 1'b1;
    tick();
    chk("sat_status", uo_out, 8'h20);
    ui_in = {6'd5, 1'b1, 1'b0};
    repeat (6) pulse(10, 10);
    to_window_end();
    tick();
    chk("alarm_thr5", uo_out, 8'h80);
    ui_in[7:2] = 6'd7;
    repeat (6) pulse(10, 10);
    to_window_end();
    tick();
    chk("alarm_thr7", uo_out, 8'h00);
    ui_in[7:2] = 6'd0;
    repeat (6) pulse(10, 10);
    to_window_end();
    tick();
    chk("alarm_thr0", uo_out, 8'h00);
    ui_in[0] = 1'b1;
    repeat (20) tick();
    chk("deb_level", uo_out, 8'h41);
    ui_in = 8'h00;
    repeat (10) tick();
    to_window_end();
    while (n % GATE != GATE - 8) tick();
    pulse(10, 10);
    chk("edge_at_end", uo_out, 8'd1);
    to_window_end();
    tick();
    chk("edge_next", uo_out, 8'd0);
    repeat (3) pulse(10, 10);
    #2 rst_n = 1'b0;
    model_reset();
    #1 chk("rst_async", uo_out, 8'h00);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (GATE) tick();
    tick();
    chk("rst_discard", uo_out, 8'h00);
    repeat (300) begin
      ui_in[0] = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) ui_in[7:1] = 7'($urandom);
      repeat ($urandom_range(1, 24)) tick();
    end
    to_window_end();
    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
